servo_sweep_pwm: RTL and testbench

- Parametrised oscillating servo driver for the MusicFan head; generalises the fixed 1000–2000 us / 35 us / 5 Hz fan sweep.
- Generates one servo PWM frame stream from the 1 MHz tick `clk_us`.
- Steps the pulse width between programmable end stops, with optional dwell at each end and a hold/freeze control.
- Single clock domain: the step rate comes from an internal frame divider, not a separate slow clock.

---
 rtl/servo_pkg.sv | 15 +
 rtl/frame_counter.sv | 27 ++
 rtl/servo_sweep_pwm.sv | 127 ++++++++++++
 tb/tb_servo_sweep_pwm.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared state encoding and default timing for the servo sweep blocks.
package servo_pkg;
   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_UP       = 3'd1,
      ST_DWELL_HI = 3'd2,
      ST_DOWN     = 3'd3,
      ST_DWELL_LO = 3'd4
   } state_t;
   localparam int DEF_PERIOD_US   = 20000;
   localparam int DEF_MIN_US      = 1000;
   localparam int DEF_MAX_US      = 2000;
   localparam int DEF_STEP_US     = 35;
   localparam int DEF_STEP_FRAMES = 10;
endpackage

// File: rtl/frame_counter.sv
// frame_counter: modulo-PERIOD_US frame counter with enable/clear, boundary strobe
// and a registered frame_start pulse one cycle after the count sits at 0.
module frame_counter #(
   parameter int W         = 15,
   parameter int PERIOD_US = 20000
) (
   input  logic         clk_us,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         boundary,
   output logic         frame_start
);
   logic run;
   assign run      = en && !clr;
   assign boundary = run && (cnt == W'(PERIOD_US - 1));
   always_ff @(posedge clk_us or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         frame_start <= 1'b0;
      end else begin
         cnt         <= clr ? '0 : !en ? cnt : boundary ? '0 : cnt + 1'b1;
         frame_start <= run && (cnt == '0);
      end
   end
endmodule

// File: rtl/servo_sweep_pwm.sv
// servo_sweep_pwm: oscillating servo PWM driver sweeping between end stops.
// Define SERVO_SWEEP_RANGE_EN to take the end stops from the lo_us/hi_us ports.
module servo_sweep_pwm
   import servo_pkg::*;
#(
   parameter int W            = 15,
   parameter int PERIOD_US    = DEF_PERIOD_US,
   parameter int MIN_US       = DEF_MIN_US,
   parameter int MAX_US       = DEF_MAX_US,
   parameter int STEP_US      = DEF_STEP_US,
   parameter int STEP_FRAMES  = DEF_STEP_FRAMES,
   parameter int DWELL_FRAMES = 0
) (
   input  logic         clk_us,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         hold,
`ifdef SERVO_SWEEP_RANGE_EN
   input  logic [W-1:0] lo_us,
   input  logic [W-1:0] hi_us,
`endif
   output logic         pwm,
   output logic [W-1:0] pos,
   output logic         dir,
   output logic [2:0]   state,
   output logic         frame_start
);
   logic [W-1:0] cnt, lo, hi, pos_c, up_pos, dn_pos, step_cnt, dwell_cnt;
   logic [W-1:0] pos_n, step_n, dwell_n;
   logic [W:0]   sum, diff;
   logic         boundary, upd, step, dwell_end, dir_n;
   state_t       st, st_n;

   frame_counter #(.W(W), .PERIOD_US(PERIOD_US)) u_frame (
      .clk_us     (clk_us),
      .rst_n      (rst_n),
      .en         (enable),
      .clr        (!enable),
      .cnt        (cnt),
      .boundary   (boundary),
      .frame_start(frame_start)
   );

   assign upd = boundary && !hold;

`ifdef SERVO_SWEEP_RANGE_EN
   logic [W-1:0] lo_r, hi_r;
   logic         range_ok;
   assign range_ok = lo_us < hi_us;
   assign lo       = range_ok ? lo_us : lo_r;
   assign hi       = range_ok ? hi_us : hi_r;
   always_ff @(posedge clk_us or negedge rst_n) begin
      if (!rst_n) begin
         lo_r <= W'(MIN_US);
         hi_r <= W'(MAX_US);
      end else if (upd) begin
         lo_r <= lo;
         hi_r <= hi;
      end
   end
`else
   assign lo = W'(MIN_US);
   assign hi = W'(MAX_US);
`endif

   // One extra bit keeps pos+STEP and pos-STEP from wrapping before the clamp.
   assign pos_c     = pos < lo ? lo : pos > hi ? hi : pos;
   assign sum       = {1'b0, pos_c} + (W+1)'(STEP_US);
   assign diff      = {1'b0, pos_c} - (W+1)'(STEP_US);
   assign up_pos    = sum >= {1'b0, hi} ? hi : sum[W-1:0];
   assign dn_pos    = (diff[W] || diff <= {1'b0, lo}) ? lo : diff[W-1:0];
   assign step      = step_cnt == W'(STEP_FRAMES - 1);
   assign dwell_end = dwell_cnt == W'(DWELL_FRAMES - 1);

   always_comb begin
      st_n    = st;
      pos_n   = pos;
      dir_n   = dir;
      step_n  = step_cnt;
      dwell_n = dwell_cnt;
      if (!enable)
         st_n = ST_OFF;
      else if (upd) begin
         pos_n = pos_c;
         case (st)
            ST_OFF: st_n = dir ? ST_DOWN : ST_UP;
            ST_UP, ST_DOWN: begin
               step_n = step ? '0 : step_cnt + 1'b1;
               if (step) begin
                  pos_n = (st == ST_UP) ? up_pos : dn_pos;
                  if ((st == ST_UP) ? (up_pos == hi) : (dn_pos == lo)) begin
                     dir_n = ~dir;
                     st_n  = (st == ST_UP) ? ((DWELL_FRAMES > 0) ? ST_DWELL_HI : ST_DOWN)
                                           : ((DWELL_FRAMES > 0) ? ST_DWELL_LO : ST_UP);
                  end
               end
            end
            ST_DWELL_HI, ST_DWELL_LO: begin
               dwell_n = dwell_end ? '0 : dwell_cnt + 1'b1;
               if (dwell_end)
                  st_n = (st == ST_DWELL_HI) ? ST_DOWN : ST_UP;
            end
            default: st_n = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_us or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_OFF;
         pos       <= W'(MIN_US);
         dir       <= 1'b0;
         step_cnt  <= '0;
         dwell_cnt <= '0;
         pwm       <= 1'b0;
      end else begin
         st        <= st_n;
         pos       <= pos_n;
         dir       <= dir_n;
         step_cnt  <= step_n;
         dwell_cnt <= dwell_n;
         pwm       <= enable && (cnt < pos);
      end
   end

   assign state = st;
endmodule

// File: tb/tb_servo_sweep_pwm.sv
// tb_servo_sweep_pwm: directed frame-by-frame table for sweeps with and without dwell,
// plus hand sequences for hold, enable drop and asynchronous reset.
module tb_servo_sweep_pwm;
   logic        clk_us = 1'b0, rst_n = 1'b0, enable = 1'b0, hold = 1'b0;
   logic        pwm, dir, frame_start, pwm0, dir0, fs0;
   logic [14:0] pos, pos0;
   logic [2:0]  state, state0;
   int          pass_n = 0, total_n = 0;

   typedef struct {
      logic en;
      logic hd;
      int   st;
      int   pos;
      int   dir;
      int   st0;
      int   pos0;
      int   dir0;
   } vec_t;
   vec_t tbl[18];

   always #5 clk_us = ~clk_us;

   servo_sweep_pwm #(.W(15), .PERIOD_US(100), .MIN_US(20), .MAX_US(40), .STEP_US(7),
                     .STEP_FRAMES(2), .DWELL_FRAMES(1)) dut (
      .clk_us(clk_us), .rst_n(rst_n), .enable(enable), .hold(hold),
      .pwm(pwm), .pos(pos), .dir(dir), .state(state), .frame_start(frame_start));

   servo_sweep_pwm #(.W(15), .PERIOD_US(100), .MIN_US(20), .MAX_US(40), .STEP_US(7),
                     .STEP_FRAMES(2), .DWELL_FRAMES(0)) dut0 (
      .clk_us(clk_us), .rst_n(rst_n), .enable(enable), .hold(hold),
      .pwm(pwm0), .pos(pos0), .dir(dir0), .state(state0), .frame_start(fs0));

   task automatic check(input string name, input int act, input int exp);
      total_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   initial begin
      int pw, fs;
      tbl[0]  = '{1'b1, 1'b0, 0, 20, 0, 0, 20, 0};
      tbl[1]  = '{1'b1, 1'b0, 1, 20, 0, 1, 20, 0};
      tbl[2]  = '{1'b1, 1'b0, 1, 20, 0, 1, 20, 0};
      tbl[3]  = '{1'b1, 1'b0, 1, 27, 0, 1, 27, 0};
      tbl[4]  = '{1'b1, 1'b0, 1, 27, 0, 1, 27, 0};
      tbl[5]  = '{1'b1, 1'b0, 1, 34, 0, 1, 34, 0};
      tbl[6]  = '{1'b1, 1'b0, 1, 34, 0, 1, 34, 0};
      tbl[7]  = '{1'b1, 1'b0, 2, 40, 1, 3, 40, 1};
      tbl[8]  = '{1'b1, 1'b0, 3, 40, 1, 3, 40, 1};
      tbl[9]  = '{1'b1, 1'b0, 3, 40, 1, 3, 33, 1};
      tbl[10] = '{1'b1, 1'b0, 3, 33, 1, 3, 33, 1};
      tbl[11] = '{1'b1, 1'b0, 3, 33, 1, 3, 26, 1};
      tbl[12] = '{1'b1, 1'b0, 3, 26, 1, 3, 26, 1};
      tbl[13] = '{1'b1, 1'b0, 3, 26, 1, 1, 20, 0};
      tbl[14] = '{1'b1, 1'b0, 4, 20, 0, 1, 20, 0};
      tbl[15] = '{1'b1, 1'b0, 1, 20, 0, 1, 27, 0};
      tbl[16] = '{1'b1, 1'b0, 1, 20, 0, 1, 27, 0};
      tbl[17] = '{1'b1, 1'b0, 1, 27, 0, 1, 34, 0};

      repeat (3) @(negedge clk_us);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_us);
      check("rst pwm", int'(pwm), 0);
      check("rst pos", int'(pos), 20);
      check("rst dir", int'(dir), 0);
      check("rst state", int'(state), 0);
      check("rst frame_start", int'(frame_start), 0);

      for (int k = 0; k < 18; k++) begin
         enable = tbl[k].en;
         hold   = tbl[k].hd;
         pw = 0;
         fs = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk_us);
            if (i == 0) begin
               check($sformatf("f%0d state", k), int'(state), tbl[k].st);
               check($sformatf("f%0d pos", k), int'(pos), tbl[k].pos);
               check($sformatf("f%0d dir", k), int'(dir), tbl[k].dir);
               check($sformatf("f%0d frame_start first", k), int'(frame_start), 1);
               check($sformatf("f%0d nodwell state", k), int'(state0), tbl[k].st0);
               check($sformatf("f%0d nodwell pos", k), int'(pos0), tbl[k].pos0);
               check($sformatf("f%0d nodwell dir", k), int'(dir0), tbl[k].dir0);
            end
            pw += int'(pwm);
            fs += int'(frame_start);
         end
         check($sformatf("f%0d pwm width", k), pw, tbl[k].pos);
         check($sformatf("f%0d frame_start count", k), fs, 1);
      end

      // Step frame at pos 27: freeze at cnt=50 for five frames.
      repeat (50) @(negedge clk_us);
      hold = 1'b1;
      for (int j = 0; j < 5; j++) begin
         pw = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk_us);
            pw += int'(pwm);
         end
         check($sformatf("hold%0d pos", j), int'(pos), 27);
         check($sformatf("hold%0d state", j), int'(state), 1);
         check($sformatf("hold%0d pwm width", j), pw, 27);
      end
      hold = 1'b0;
      repeat (49) @(negedge clk_us);
      check("release pos before boundary", int'(pos), 27);
      @(negedge clk_us);
      check("release pos after boundary", int'(pos), 34);
      check("release state", int'(state), 1);

      repeat (10) @(negedge clk_us);
      check("pre-drop pwm", int'(pwm), 1);
      enable = 1'b0;
      @(negedge clk_us);
      check("drop pwm", int'(pwm), 0);
      check("drop state", int'(state), 0);
      check("drop pos", int'(pos), 34);
      check("drop dir", int'(dir), 0);
      pw = 0;
      fs = 0;
      repeat (5) begin
         @(negedge clk_us);
         pw += int'(pwm);
         fs += int'(frame_start);
      end
      check("off pwm count", pw, 0);
      check("off frame_start count", fs, 0);
      enable = 1'b1;
      @(negedge clk_us);
      check("reenable pwm", int'(pwm), 1);
      check("reenable frame_start", int'(frame_start), 1);
      repeat (99) @(negedge clk_us);
      check("reenable state", int'(state), 1);
      check("reenable pos", int'(pos), 34);

      repeat (10) @(negedge clk_us);
      check("pre-reset pwm", int'(pwm), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst pwm", int'(pwm), 0);
      check("async rst pos", int'(pos), 20);
      check("async rst state", int'(state), 0);
      @(negedge clk_us);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
